// File: rtl/controle_mac_pkg.sv
// rtl/controle_mac_pkg.sv - shared constants for the MAC controller
// Purpose: FSM state encoding, default operand width, accumulator width
//          rule, pair counter width and the pair limit.
package controle_mac_pkg;

  localparam int DEF_N = 8;

  // Accumulator/result width for an N-bit multiplier: product width plus
  // four guard bits, enough for 16 full-scale products.
  function automatic int acc_w(input int n);
    return 2 * n + 4;
  endfunction

  localparam int              CNT_W      = 5;
  localparam logic [CNT_W-1:0] PAIR_LIMIT = 5'd16;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_ACC   = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

endpackage

// File: rtl/controle_mac_acumulador_reg.sv
// rtl/controle_mac_acumulador_reg.sv - sum/count accumulator with sticky overflow
// Purpose: holds the running sum of products, the pair count (saturating at
//          PAIR_LIMIT) and the sticky ovf flag.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   i_add           add i_prod into the sum this cycle
//   i_clr           clear sum, count and ovf (has priority over i_add)
//   i_prod          product, zero-extended into the sum
//   o_sum, o_count, o_ovf   accumulator state
module acumulador_reg
  import controle_mac_pkg::*;
#(
  parameter int P_W   = 16,
  parameter int ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_add,
  input  logic             i_clr,
  input  logic [P_W-1:0]   i_prod,
  output logic [ACC_W-1:0] o_sum,
  output logic [CNT_W-1:0] o_count,
  output logic             o_ovf
);

  logic [ACC_W-1:0] r_sum;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sum   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_clr) begin
      r_sum   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else if (i_add) begin
      // Sum wraps modulo 2^ACC_W; it keeps accumulating even past the limit.
      r_sum <= r_sum + ACC_W'(i_prod);
      if (r_count == PAIR_LIMIT) begin
        r_ovf <= 1'b1;
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign o_sum   = r_sum;
  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: rtl/controle_mac.sv
// rtl/controle_mac.sv - dot-product controller driving an external multiplier
// Purpose: accepts operand pairs, starts the external multiplier for each,
//          accumulates products and presents the sum when the last pair is in.
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   in_valid/in_ready/in_a/in_b/in_last   operand pair input handshake
//   mul_start/mul_b/mul_q         multiplier control and operands
//   mul_done/mul_p                multiplier completion and product
//   out_valid/out_ready           result handshake
//   out_sum/out_count/ovf         result, pair count, overflow flag
module controle_mac
  import controle_mac_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int ACC_W = acc_w(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_a,
  input  logic [N-1:0]     in_b,
  input  logic             in_last,
  output logic             mul_start,
  output logic [N-1:0]     mul_b,
  output logic [N-1:0]     mul_q,
  input  logic             mul_done,
  input  logic [2*N-1:0]   mul_p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             ovf
);

  logic [2:0]     r_state;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic           r_last;
  logic [2*N-1:0] r_prod;
  // Goes high on the first edge after reset release; keeps in_ready low
  // while reset is held and during the release cycle.
  logic           r_alive;

  logic w_add;
  logic w_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_last  <= 1'b0;
      r_prod  <= '0;
      r_alive <= 1'b0;
    end else begin
      r_alive <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_last  <= in_last;
            r_state <= S_START;
          end
        end
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          // Capture the product with its done flag so the add in ACC does
          // not depend on the multiplier holding P_out afterwards.
          if (mul_done) begin
            r_prod  <= mul_p;
            r_state <= S_ACC;
          end
        end
        S_ACC:   r_state <= r_last ? S_OUT : S_IDLE;
        S_OUT: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_add = (r_state == S_ACC);
  assign w_clr = (r_state == S_OUT) && out_ready;

  acumulador_reg #(
    .P_W  (2 * N),
    .ACC_W(ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst    (rst),
    .i_add  (w_add),
    .i_clr  (w_clr),
    .i_prod (r_prod),
    .o_sum  (out_sum),
    .o_count(out_count),
    .o_ovf  (ovf)
  );

  assign in_ready  = (r_state == S_IDLE) && r_alive;
  assign out_valid = (r_state == S_OUT);
  assign mul_start = (r_state == S_START);
  assign mul_b     = r_a;
  assign mul_q     = r_b;

endmodule

// File: tb/tb_controle_mac.sv
// tb/tb_controle_mac.sv - self-checking bench for controle_mac
module tb_controle_mac;

  localparam int N     = 8;
  localparam int ACC_W = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N-1:0]     in_a = '0;
  logic [N-1:0]     in_b = '0;
  logic             in_last = 1'b0;
  logic             mul_start;
  logic [N-1:0]     mul_b;
  logic [N-1:0]     mul_q;
  logic             mul_done = 1'b0;
  logic [2*N-1:0]   mul_p = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic [4:0]       out_count;
  logic             ovf;

  controle_mac #(.N(N), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .mul_start(mul_start),
    .mul_b    (mul_b),
    .mul_q    (mul_q),
    .mul_done (mul_done),
    .mul_p    (mul_p),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Multiplier stand-in: latency drawn from [lat_min, lat_max] cycles after
  // mul_start; P_out is garbage except during the done cycle.
  int          lat_min = 0;
  int          lat_max = 3;
  int          mcnt = -1;
  logic        force_done = 1'b0;
  logic [N-1:0] pa, pb;

  initial begin
    forever begin
      @(negedge clk);
      mul_done = 1'b0;
      if (!rst) begin
        mcnt = -1;
      end else if (force_done) begin
        mul_done = 1'b1;
        mul_p    = 16'($urandom);
      end else begin
        if (mcnt > 0) begin
          mcnt--;
          mul_p = 16'($urandom);
        end else if (mcnt == 0) begin
          mul_done = 1'b1;
          mul_p    = pa * pb;
          mcnt     = -1;
        end else begin
          mul_p = 16'($urandom);
        end
        if (mul_start) begin
          pa   = mul_b;
          pb   = mul_q;
          mcnt = $urandom_range(lat_max, lat_min);
        end
      end
    end
  end

  // Reference model: dot product of everything accepted since the last result.
  longint m_sum = 0;
  int     m_n   = 0;

  task automatic send_pair(input logic [N-1:0] a, input logic [N-1:0] b, input logic last);
    int k;
    int starts;
    logic bad;
    k = 0;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("in_ready_wait", in_ready, 1);
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    @(negedge clk);
    in_valid = 1'b0; in_a = N'($urandom); in_b = N'($urandom); in_last = 1'($urandom);
    check("mul_start_t1", mul_start, 1);
    starts = 0; bad = 1'b0; k = 0;
    while (!in_ready && !out_valid && k < 200) begin
      if (mul_start) starts++;
      if (mul_b !== a || mul_q !== b) bad = 1'b1;
      @(negedge clk);
      k++;
    end
    check("mul_start_once", starts, 1);
    check("operands_stable", bad, 0);
    check("pair_complete", (k < 200), 1);
    m_sum = (m_sum + longint'(a) * longint'(b)) % (longint'(1) << ACC_W);
    m_n++;
  endtask

  task automatic get_result(input int hold);
    int k;
    logic bad;
    logic [ACC_W-1:0] s0;
    k = 0;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("out_valid_wait", out_valid, 1);
    check("out_sum", out_sum, m_sum);
    check("out_count", out_count, (m_n > 16) ? 16 : m_n);
    check("ovf", ovf, (m_n > 16) ? 1 : 0);
    s0 = out_sum;
    bad = 1'b0;
    repeat (hold) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== s0) bad = 1'b1;
    end
    if (hold > 0) check("hold_stable", bad, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_released", out_valid, 0);
    check("cleared", {out_sum, out_count, ovf}, 0);
    check("in_ready_after_out", in_ready, 1);
    m_sum = 0;
    m_n   = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int len;
    #12;
    check("reset_state", {in_ready, out_valid, mul_start, out_sum, out_count, ovf, mul_b, mul_q}, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 check("in_ready_before_edge", in_ready, 0);
    @(negedge clk);
    check("in_ready_after_release", in_ready, 1);

    // Single pair
    send_pair(8'd11, 8'd17, 1'b1);
    check("single_sum_187", out_sum, 187);
    get_result(0);

    // Three pairs
    send_pair(8'd3, 8'd4, 1'b0);
    send_pair(8'd5, 8'd6, 1'b0);
    send_pair(8'd7, 8'd8, 1'b1);
    check("three_sum_98", out_sum, 98);
    get_result(0);

    // Stray mul_done in IDLE and in OUT; held result in OUT
    send_pair(8'd3, 8'd4, 1'b0);
    force_done = 1'b1;
    repeat (3) @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    check("idle_done_ignored", {in_ready, out_sum, out_count}, {1'b1, 20'd12, 5'd1});
    send_pair(8'd1, 8'd1, 1'b1);
    force_done = 1'b1;
    repeat (3) @(negedge clk);
    force_done = 1'b0;
    @(negedge clk);
    check("out_done_ignored", {out_valid, out_sum, out_count}, {1'b1, 20'd13, 5'd2});
    get_result(5);

    // 16 full-scale pairs, then 17
    lat_max = 0;
    for (int i = 0; i < 16; i++) send_pair(8'd255, 8'd255, (i == 15));
    check("sixteen_sum", out_sum, 1040400);
    get_result(0);
    for (int i = 0; i < 17; i++) send_pair(8'd255, 8'd255, (i == 16));
    check("seventeen_ovf", {ovf, out_count}, {1'b1, 5'd16});
    get_result(2);
    lat_max = 3;

    // Reset mid-cycle while waiting for the multiplier
    send_pair(8'd9, 8'd9, 1'b0);
    lat_min = 40; lat_max = 40;
    in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("reset_in_wait", {in_ready, out_valid, mul_start, out_sum, out_count, ovf, mul_b, mul_q}, 0);
    @(negedge clk);
    rst = 1'b1;
    m_sum = 0; m_n = 0;
    lat_min = 0; lat_max = 3;
    @(negedge clk);
    check("in_ready_after_reset", in_ready, 1);
    send_pair(8'd2, 8'd3, 1'b1);
    check("fresh_sum_6", out_sum, 6);
    get_result(0);

    // Random dot products
    for (int t = 0; t < 8; t++) begin
      len = $urandom_range(20, 1);
      for (int i = 0; i < len; i++) send_pair(N'($urandom), N'($urandom), (i == len - 1));
      get_result($urandom_range(2, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
